gshare_predictor: RTL and testbench



---
 rtl/bp_pkg.sv | 32 +++
 rtl/gshare_pht.sv | 39 +++
 rtl/gshare_predictor.sv | 99 +++++++++
 tb/tb_gshare_predictor.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
// Shared helpers for branch predictors: saturating-counter constants and
// update rule, plus the PC/history lookup-index hash.
package bp_pkg;

    localparam int MAX_CNT_BITS = 4;

    typedef logic [MAX_CNT_BITS-1:0] cnt_t;

    function automatic cnt_t cnt_init(int cnt_bits);
        return cnt_t'((1 << (cnt_bits - 1)) - 1);
    endfunction

    function automatic cnt_t cnt_max(int cnt_bits);
        return cnt_t'((1 << cnt_bits) - 1);
    endfunction

    function automatic cnt_t sat_update(cnt_t cnt, logic taken, int cnt_bits);
        if (taken)
            return (cnt == cnt_max(cnt_bits)) ? cnt : cnt + cnt_t'(1);
        else
            return (cnt == '0) ? cnt : cnt - cnt_t'(1);
    endfunction

    // Word-aligned PC bits XOR history, wrapped to the table size.
    function automatic logic [31:0] lookup_index(logic [63:0] pc, logic [31:0] ghr,
                                                 int idx_bits);
        logic [31:0] mask;
        mask = (32'd1 << idx_bits) - 32'd1;
        return (pc[33:2] ^ ghr) & mask;
    endfunction

endpackage

// File: rtl/gshare_pht.sv
// Pattern history table: 2^IDX_BITS saturating counters, asynchronous read,
// synchronous read-modify-write update, whole-table synchronous init.
module gshare_pht
    import bp_pkg::*;
#(
    parameter int IDX_BITS = 8,
    parameter int CNT_BITS = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [IDX_BITS-1:0] rd_idx,
    output logic [CNT_BITS-1:0] rd_cnt,
    input  logic                wr_en,
    input  logic [IDX_BITS-1:0] wr_idx,
    input  logic                wr_taken
);

    localparam int DEPTH = 1 << IDX_BITS;
    localparam logic [CNT_BITS-1:0] INIT = CNT_BITS'(cnt_init(CNT_BITS));

    logic [CNT_BITS-1:0] mem [DEPTH];
    logic [CNT_BITS-1:0] wr_next;

    // No bypass: a same-cycle write is seen by the read port only next cycle.
    assign rd_cnt  = mem[rd_idx];
    assign wr_next = CNT_BITS'(sat_update(MAX_CNT_BITS'(mem[wr_idx]), wr_taken, CNT_BITS));

    // NOTE: resetting every entry in one cycle forces flop storage rather than
    // an SRAM macro; that is the price of losing all training instantly on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= INIT;
        end else if (wr_en) begin
            mem[wr_idx] <= wr_next;
        end
    end

endmodule

// File: rtl/gshare_predictor.sv
// Gshare branch direction predictor with speculative, repairable global history.
// HIST_BITS = 0 gives plain bimodal. Define GSHARE_STATS_EN to build statistics counters.
module gshare_predictor
    import bp_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int IDX_BITS  = 8,
    parameter int CNT_BITS  = 2,
    parameter int HIST_BITS = 8,
    parameter int STAT_BITS = 32,
    localparam int GW       = (HIST_BITS > 0) ? HIST_BITS : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 pred_valid,
    input  logic [XLEN-1:0]      pred_pc,
    output logic                 pred_taken,
    output logic [GW-1:0]        pred_ghr,
    input  logic                 res_valid,
    input  logic [XLEN-1:0]      res_pc,
    input  logic [GW-1:0]        res_ghr,
    input  logic                 res_taken,
    input  logic                 res_pred,
    output logic                 res_mispredict,
    output logic [STAT_BITS-1:0] stat_branches,
    output logic [STAT_BITS-1:0] stat_mispred
);

    logic [GW-1:0]       ghr;
    logic [31:0]         pred_lookup;
    logic [31:0]         res_lookup;
    logic [CNT_BITS-1:0] pred_cnt;

    assign res_mispredict = res_valid && (res_taken != res_pred);

    if (HIST_BITS > 0) begin : g_hist
        // Repair beats the speculative shift: the branch in IF is being flushed.
        always_ff @(posedge clk) begin
            if (reset)
                ghr <= '0;
            else if (res_mispredict)
                ghr <= GW'({res_ghr, res_taken});
            else if (pred_valid)
                ghr <= GW'({ghr, pred_taken});
        end
        assign pred_lookup = lookup_index(64'(pred_pc), 32'(ghr), IDX_BITS);
        assign res_lookup  = lookup_index(64'(res_pc), 32'(res_ghr), IDX_BITS);
        assign pred_ghr    = ghr;
    end else begin : g_bimodal
        assign ghr         = '0;
        assign pred_lookup = lookup_index(64'(pred_pc), 32'd0, IDX_BITS);
        assign res_lookup  = lookup_index(64'(res_pc), 32'd0, IDX_BITS);
        assign pred_ghr    = '0;
    end

    gshare_pht #(
        .IDX_BITS (IDX_BITS),
        .CNT_BITS (CNT_BITS)
    ) u_pht (
        .clk      (clk),
        .reset    (reset),
        .rd_idx   (pred_lookup[IDX_BITS-1:0]),
        .rd_cnt   (pred_cnt),
        .wr_en    (res_valid),
        .wr_idx   (res_lookup[IDX_BITS-1:0]),
        .wr_taken (res_taken)
    );

    assign pred_taken = pred_cnt[CNT_BITS-1];

`ifdef GSHARE_STATS_EN
    logic [STAT_BITS-1:0] branches_q;
    logic [STAT_BITS-1:0] mispred_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            branches_q <= '0;
            mispred_q  <= '0;
        end else begin
            if (res_valid)
                branches_q <= branches_q + STAT_BITS'(1);
            if (res_mispredict)
                mispred_q <= mispred_q + STAT_BITS'(1);
        end
    end

    assign stat_branches = branches_q;
    assign stat_mispred  = mispred_q;
`else
    assign stat_branches = '0;
    assign stat_mispred  = '0;
`endif

    // Upper hash bits, aliased PC bits and (in bimodal mode) history are don't-cares.
    logic unused_ok;
    assign unused_ok = ^{pred_lookup, res_lookup, pred_pc, res_pc, res_ghr, ghr,
                         pred_valid, pred_cnt};

endmodule

// File: tb/tb_gshare_predictor.sv
// Scoreboard bench for gshare_predictor: a gshare instance (HIST_BITS=8) and a
// bimodal instance (HIST_BITS=0) driven by directed vectors.
module tb_gshare_predictor;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // gshare instance signals
    logic        pred_valid, pred_taken, res_valid, res_taken, res_pred, res_mispredict;
    logic [31:0] pred_pc, res_pc, stat_branches, stat_mispred;
    logic [7:0]  pred_ghr, res_ghr;

    // bimodal instance signals
    logic        b_pred_valid, b_pred_taken, b_res_valid, b_res_taken, b_res_pred;
    logic        b_res_mispredict;
    logic [31:0] b_pred_pc, b_res_pc, b_stat_branches, b_stat_mispred;
    logic [0:0]  b_pred_ghr, b_res_ghr;

    gshare_predictor u_dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_ghr       (pred_ghr),
        .res_valid      (res_valid),
        .res_pc         (res_pc),
        .res_ghr        (res_ghr),
        .res_taken      (res_taken),
        .res_pred       (res_pred),
        .res_mispredict (res_mispredict),
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
    );

    gshare_predictor #(.HIST_BITS(0)) u_bim (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (b_pred_valid),
        .pred_pc        (b_pred_pc),
        .pred_taken     (b_pred_taken),
        .pred_ghr       (b_pred_ghr),
        .res_valid      (b_res_valid),
        .res_pc         (b_res_pc),
        .res_ghr        (b_res_ghr),
        .res_taken      (b_res_taken),
        .res_pred       (b_res_pred),
        .res_mispredict (b_res_mispredict),
        .stat_branches  (b_stat_branches),
        .stat_mispred   (b_stat_mispred)
    );

    typedef enum {K_TAKEN, K_GHR, K_MISP, K_SBR, K_SMP, K_BTAKEN, K_BGHR, K_BMISP} kind_e;

    typedef struct {
        int          cyc;
        kind_e       kind;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] observe(kind_e k);
        case (k)
            K_TAKEN:  return 32'(pred_taken);
            K_GHR:    return 32'(pred_ghr);
            K_MISP:   return 32'(res_mispredict);
            K_SBR:    return stat_branches;
            K_SMP:    return stat_mispred;
            K_BTAKEN: return 32'(b_pred_taken);
            K_BGHR:   return 32'(b_pred_ghr);
            default:  return 32'(b_res_mispredict);
        endcase
    endfunction

    task automatic check(exp_t e);
        logic [31:0] act;
        act = observe(e.kind);
        compared++;
        if (act !== e.val) begin
            mismatched++;
            $display("FAIL %s (cycle %0d): got 0x%0h, want 0x%0h", e.name, e.cyc, act, e.val);
        end
    endtask

    // Monitor: compares every queued expectation due in the current cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            exp_t e;
            e = sb.pop_front();
            if (e.cyc < cyc) begin
                compared++;
                mismatched++;
                $display("FAIL %s: expectation for cycle %0d never sampled", e.name, e.cyc);
            end else begin
                check(e);
            end
        end
    end

    task automatic want(int dc, kind_e k, logic [31:0] v, string name);
        exp_t e;
        e.cyc  = cyc + dc;
        e.kind = k;
        e.val  = v;
        e.name = name;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] st(int v);
`ifdef GSHARE_STATS_EN
        return 32'(v);
`else
        return 32'(v * 0);
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        pred_valid   = 1'b0;
        res_valid    = 1'b0;
        b_pred_valid = 1'b0;
        b_res_valid  = 1'b0;
    endtask

    logic [7:0] bim_seq;
    logic [7:0] bim_exp;

    initial begin
        reset = 1'b1;
        idle();
        pred_pc = '0; res_pc = '0; res_ghr = '0; res_taken = 1'b0; res_pred = 1'b0;
        b_pred_pc = '0; b_res_pc = '0; b_res_ghr = '0; b_res_taken = 1'b0; b_res_pred = 1'b0;
        // activity during reset must be ignored
        pred_valid = 1'b1; res_valid = 1'b1; res_taken = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        idle();

        // reset state and first prediction
        pred_valid = 1'b1; pred_pc = 32'h100;
        want(0, K_TAKEN, 0, "rst_pred_taken");
        want(0, K_GHR, 0, "rst_pred_ghr");
        want(0, K_SBR, 0, "rst_stat_branches");
        want(0, K_SMP, 0, "rst_stat_mispred");
        want(0, K_BTAKEN, 0, "bim_rst_pred_taken");
        want(1, K_GHR, 0, "ghr_after_nt_shift");
        tick();
        idle();

        // train entries 0x80 and 0xC1 toward taken
        res_valid = 1'b1; res_pc = 32'h200; res_ghr = 8'h00; res_taken = 1'b1; res_pred = 1'b1;
        want(0, K_MISP, 0, "no_mispredict");
        tick();
        res_pc = 32'h300; res_ghr = 8'h01;
        tick();
        idle();

        // speculative history: taken, taken, not-taken
        pred_valid = 1'b1; pred_pc = 32'h200;
        want(0, K_TAKEN, 1, "spec_p1_taken");
        want(0, K_GHR, 32'h00, "spec_p1_ghr");
        tick();
        pred_pc = 32'h300;
        want(0, K_TAKEN, 1, "spec_p2_taken");
        want(0, K_GHR, 32'h01, "spec_p2_ghr");
        tick();
        pred_pc = 32'h400;
        want(0, K_TAKEN, 0, "spec_p3_taken");
        want(0, K_GHR, 32'h03, "spec_p3_ghr");
        want(1, K_GHR, 32'h06, "ghr_110");
        tick();
        idle();

        // mispredict repair
        res_valid = 1'b1; res_pc = 32'h500; res_ghr = 8'h01; res_taken = 1'b1; res_pred = 1'b0;
        want(0, K_MISP, 1, "mispredict_flag");
        want(1, K_GHR, 32'h03, "ghr_repair_011");
        tick();

        // repair and prediction in the same cycle
        res_pc = 32'h700; res_ghr = 8'h05; res_taken = 1'b0; res_pred = 1'b1;
        pred_valid = 1'b1; pred_pc = 32'h600;
        want(0, K_GHR, 32'h03, "pre_repair_ghr");
        want(0, K_MISP, 1, "mispredict_flag_2");
        want(1, K_GHR, 32'h0A, "repair_wins_over_shift");
        tick();
        idle();

        // same-entry update and lookup: no bypass
        pred_pc = 32'h800;
        res_valid = 1'b1; res_pc = 32'h800; res_ghr = 8'h0A; res_taken = 1'b1; res_pred = 1'b1;
        want(0, K_TAKEN, 0, "no_bypass_old_value");
        want(1, K_TAKEN, 1, "new_value_next_cycle");
        tick();
        idle();
        want(0, K_SBR, st(5), "stat_branches_5");
        want(0, K_SMP, st(2), "stat_mispred_2");
        tick();

        // mid-run reset with concurrent activity
        reset = 1'b1;
        pred_valid = 1'b1; pred_pc = 32'h200;
        res_valid = 1'b1; res_pc = 32'h200; res_ghr = 8'h00; res_taken = 1'b0; res_pred = 1'b1;
        tick();
        reset = 1'b0;
        idle();
        want(0, K_SBR, 0, "midrst_stat_branches");
        want(0, K_SMP, 0, "midrst_stat_mispred");
        want(0, K_GHR, 0, "midrst_ghr");
        for (int i = 0; i < 256; i++) begin
            pred_pc = 32'(i) << 2;
            want(0, K_TAKEN, 0, $sformatf("sweep_idx_%0d", i));
            tick();
        end

        // 0xC5 was driven to 0 before the reset; one taken update must make it taken
        res_valid = 1'b1; res_pc = 32'h314; res_ghr = 8'h00; res_taken = 1'b1; res_pred = 1'b1;
        tick();
        res_valid = 1'b0;
        pred_pc = 32'h314;
        want(0, K_TAKEN, 1, "init_is_weakly_nt");
        tick();

        // nine more resolves, three of them mispredicted
        for (int i = 0; i < 9; i++) begin
            res_valid = 1'b1;
            res_pc    = 32'h900 + (32'(i) << 2);
            res_ghr   = 8'(i);
            res_taken = (i % 2) == 1;
            res_pred  = (i < 3) ? !res_taken : res_taken;
            tick();
        end
        idle();
        want(0, K_SBR, st(10), "stat_branches_10");
        want(0, K_SMP, st(3), "stat_mispred_3");
        tick();

        // bimodal: saturate at max, walk down, saturate at 0
        bim_seq = 8'b1000_0111;
        bim_exp = 8'b0001_1110;
        b_pred_pc = 32'h100; b_res_pc = 32'h100; b_res_ghr = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b_res_valid = 1'b1;
            b_res_taken = bim_seq[i];
            b_res_pred  = bim_seq[i];
            want(0, K_BTAKEN, 32'(bim_exp[i]), $sformatf("bim_step_%0d", i));
            want(0, K_BGHR, 0, $sformatf("bim_ghr_%0d", i));
            tick();
        end
        b_res_valid = 1'b1; b_res_taken = 1'b0; b_res_pred = 1'b1;
        want(0, K_BTAKEN, 0, "bim_after_floor");
        want(0, K_BMISP, 1, "bim_mispredict");
        tick();
        idle();

        for (int t = 0; t < 20 && sb.size() > 0; t++)
            tick();
        if (sb.size() > 0) begin
            $display("FAIL drain_timeout: %0d expectations left, want 0", sb.size());
            compared += sb.size();
            mismatched += sb.size();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
